mesh_out_arbiter: RTL
=====================

# mesh_out_arbiter

Round-robin output-port arbiter and one-entry output register for one output direction of `mesh_router`. Five requesters compete for the port: the North, East, South and West input ports and the PE injection port. The block picks one winner per free slot, captures that packet, and presents it downstream with a send/ready handshake. `mesh_router` instantiates it once per output port: east, north, south, west and peout.

## Interface
Parameters:
- PKTWIDTH, 64, packet width in bits.
- NREQ, 5, number of requesters. Index mapping: 0=N, 1=E, 2=S, 3=W, 4=PE.
- STALL_LIMIT, 15, number of consecutive stalled cycles before `stall_err` (range 1..255). Used only when ARB_STALL_MON_EN is defined.

Ports:
- clk  in  1  the single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester "packet routed to this port" request.
- data_in  in  NREQ*PKTWIDTH  flattened packets; requester i drives `[i*PKTWIDTH +: PKTWIDTH]`.
- grant  out  NREQ  one-hot, combinational; high only in the cycle requester i's packet is captured.
- dataout  out  PKTWIDTH  registered packet to downstream.
- so  out  1  send-out: `dataout` holds a valid packet.
- ro  in  1  downstream ready. A transfer occurs on any cycle with so=1 and ro=1.
- stall_err  out  1  sticky stall flag; tied 0 without ARB_STALL_MON_EN.

## Operation
- State: `full` (equals so), output register `dataout`, round-robin pointer `ptr` (3 bits, last winner index).
- load_ok = !full | ro.
- Winner selection: when load_ok and |req, the winner is the first i with req[i]=1, searching ptr+1, ptr+2, … modulo NREQ.
  - grant = onehot(winner); otherwise grant = 0.
  - grant is forced to 0 while reset=1.
- On the clock edge with a grant: dataout <= data_in[winner], full <= 1, ptr <= winner.
- Transfer without a new grant: full <= 0; dataout keeps its last value.
- Stalled (full and !ro): dataout, ptr and full hold; grant = 0 regardless of req.
- A requester sees grant[i] in the cycle it is taken and must advance or drop req[i] for the next cycle. A req that stays high is treated as a new packet.
- A requester that is not granted keeps req high. No packet is lost or duplicated.
- ptr arithmetic wraps: 4+1 -> 0.
- Reset values: dataout=0, so=0, ptr=NREQ-1 (so index 0 wins first), stall_err=0, stall counter=0.
- Reset mid-operation: a held packet is discarded and arbitration restarts from index 0.

## Timing
- Latency: req in cycle T with load_ok -> grant in T -> so=1 and dataout valid in T+1.
- Throughput: one packet per cycle while ro=1. A transfer and a new capture happen on the same edge, so so stays high back-to-back.
- With ro=0 and full=1, so stays high and dataout is stable until the first cycle with ro=1.
- Simultaneous requests never produce more than one grant bit.
- A new request in the same cycle a transfer completes is granted in that cycle.

## Configuration
- Macro ARB_STALL_MON_EN.
- Defined:
  - An 8-bit saturating counter increments each cycle with so && !ro.
  - The counter clears on a transfer or on reset.
  - When the counter reaches STALL_LIMIT, stall_err is set on the following edge.
  - stall_err is sticky until reset.
- Undefined: no counter logic; stall_err is a constant 0.

## Test plan
- Single request: after reset, req=5'b00001, data_in[0]=64'd9, ro=1 -> grant=00001 in T; so=1, dataout=64'd9 in T+1; so=0 in T+2 once req has dropped.
- Full round-robin: req=5'b11111 held, ro=1 -> grants 0,1,2,3,4,0,1 on consecutive cycles; so continuously 1; dataout follows the granted data one cycle later.
- Stall and release:
  - Stimulus: req N+E with N=64'h2001BBBBCCCCCCCC and E=64'h2001DDDDAAAAAAAA, ro=0.
  - Expected: N granted once; dataout holds the N value; grant=0 for 3 stalled cycles.
  - Then ro=1 for one cycle: N transfers and E is granted in that same cycle; dataout=E on the next cycle.
- Reset while full: load a packet with ro=0, then assert reset for one cycle -> next cycle so=0, dataout=0. Then req=11111 -> grant index 0 first.
- Stall monitor (ARB_STALL_MON_EN, STALL_LIMIT=15):
  - so=1 with ro=0 for cycles T+1..T+15 -> stall_err=1 at T+16 and stays 1 after ro returns to 1.
  - With only 14 stalled cycles followed by a transfer -> stall_err stays 0.
- Wrap/priority: ptr=4 after a PE grant, req=5'b10001 -> index 0 wins next; then with req still 5'b10001, index 4 wins.

Source files
------------

// File: rtl/mesh_out_arbiter_if.sv
// mesh_out_arbiter_if
// Bundles the requester side (req, data_in, grant) and the downstream side
// (dataout, so, ro) of one output-port arbiter, plus the stall flag.
//   slave  : the arbiter; samples req/data_in/ro and drives grant/dataout/so/stall_err
//   master : the surrounding router (or a bench); drives req/data_in/ro
interface mesh_out_arbiter_if #(
  parameter int PKTWIDTH = 64,
  parameter int NREQ     = 5
);
  logic [NREQ-1:0]          req;
  logic [NREQ*PKTWIDTH-1:0] data_in;
  logic [NREQ-1:0]          grant;
  logic [PKTWIDTH-1:0]      dataout;
  logic                     so;
  logic                     ro;
  logic                     stall_err;

  modport slave (
    input  req, data_in, ro,
    output grant, dataout, so, stall_err
  );

  modport master (
    output req, data_in, ro,
    input  grant, dataout, so, stall_err
  );
endinterface

// File: rtl/mesh_out_arbiter.sv
// mesh_out_arbiter
// Round-robin arbiter plus one-entry output register for a single output
// direction of mesh_router. Requesters: 0=N, 1=E, 2=S, 3=W, 4=PE.
// Ports:
//   clk    : clock, all state updates on posedge
//   reset  : synchronous, active-high
//   bus    : mesh_out_arbiter_if.slave
//            req/data_in  - per-requester request and flattened packets
//            grant        - one-hot, combinational, high in the capture cycle
//            dataout/so   - registered packet and its valid flag
//            ro           - downstream ready; transfer when so && ro
//            stall_err    - sticky stall flag
// Optional feature: define ARB_STALL_MON_EN to build the stall monitor
// (8-bit saturating stall counter, stall_err set once it reaches
// STALL_LIMIT). Without it stall_err is tied to 0.
module mesh_out_arbiter #(
  parameter int PKTWIDTH    = 64,
  parameter int NREQ        = 5,
  parameter int STALL_LIMIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  mesh_out_arbiter_if.slave bus
);

  logic                full_q, full_d;
  logic [PKTWIDTH-1:0] dataout_q, dataout_d;
  logic [2:0]          ptr_q, ptr_d;

  logic                load_ok;
  logic                win_vld;
  logic [2:0]          win_idx;
  logic                grant_vld;
  logic [PKTWIDTH-1:0] win_data;
  logic                xfer;
  int                  idx;

  // Selection: scan ptr+1, ptr+2, ... (mod NREQ); the first requester found wins.
  always_comb begin
    load_ok = !full_q || bus.ro;
    xfer    = full_q && bus.ro;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = 3'(idx);
      end
    end
    grant_vld = win_vld && load_ok && !reset;

    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == 3'(i)) win_data = bus.data_in[i*PKTWIDTH +: PKTWIDTH];
    end
  end

  assign bus.grant = grant_vld ? (NREQ'(1) << win_idx) : '0;

  // Next state: capture on grant (which may coincide with a transfer),
  // otherwise a transfer just empties the register and dataout keeps its value.
  always_comb begin
    full_d    = full_q;
    dataout_d = dataout_q;
    ptr_d     = ptr_q;
    if (grant_vld) begin
      full_d    = 1'b1;
      dataout_d = win_data;
      ptr_d     = win_idx;
    end else if (xfer) begin
      full_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= 1'b0;
      dataout_q <= '0;
      ptr_q     <= 3'(NREQ - 1);
    end else begin
      full_q    <= full_d;
      dataout_q <= dataout_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.so      = full_q;
  assign bus.dataout = dataout_q;

`ifdef ARB_STALL_MON_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       stall_err_q, stall_err_d;

  // The flag rises on the same edge the counter reaches the limit, so it is
  // visible in the cycle right after the STALL_LIMIT-th stalled cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (xfer) begin
      stall_cnt_d = '0;
    end else if (full_q && !bus.ro && stall_cnt_q != 8'hFF) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
    stall_err_d = stall_err_q || (stall_cnt_d >= 8'(STALL_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign bus.stall_err = stall_err_q;
`else
  assign bus.stall_err = 1'b0;
`endif

endmodule
